axi4_lite_rr_arbiter: RTL and testbench

- Shares one AXI4-Lite slave port between two AXI4-Lite masters. It is the converse of the bus sunder: N:1 joining instead of 1:N splitting.
- Write and read channels are arbitrated independently. Each channel carries at most one transaction at a time.
- Arbitration is round-robin, or fixed priority when selected.
- Typical use: two CSR requesters (for example host bridge and debug port) sharing one register bank or one sunder tree.

---
 rtl/axi4_lite_rr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_axi4_lite_rr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_lite_rr_arbiter
//
// Joins two AXI4-Lite masters onto one AXI4-Lite slave port. The write and
// read channels each run their own three-state arbiter and carry at most one
// transaction at a time. Once a grant is registered, forwarding is purely
// combinational: no buffering and no added latency per beat.
//
// Parameters
//   ADDR_W  address width shared by all three ports
//   DATA_W  data width shared by all three ports (wstrb is DATA_W/8)
//   RR      1 = round-robin between tied requesters, 0 = master 0 wins ties
//
// Ports
//   aclk, aresetn       clock (rising edge), asynchronous active-low reset
//   s_*_i / s_*_o       upstream masters; index [0] and [1] of each bus
//   m_*_o / m_*_i       downstream shared slave
// -----------------------------------------------------------------------------
module axi4_lite_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR     = 1'b1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  // upstream masters
  input  logic [1:0]                   s_awvalid_i,
  output logic [1:0]                   s_awready_o,
  input  logic [1:0][ADDR_W-1:0]       s_awaddr_i,
  input  logic [1:0][2:0]              s_awprot_i,
  input  logic [1:0]                   s_wvalid_i,
  output logic [1:0]                   s_wready_o,
  input  logic [1:0][DATA_W-1:0]       s_wdata_i,
  input  logic [1:0][DATA_W/8-1:0]     s_wstrb_i,
  output logic [1:0]                   s_bvalid_o,
  input  logic [1:0]                   s_bready_i,
  output logic [1:0][1:0]              s_bresp_o,
  input  logic [1:0]                   s_arvalid_i,
  output logic [1:0]                   s_arready_o,
  input  logic [1:0][ADDR_W-1:0]       s_araddr_i,
  input  logic [1:0][2:0]              s_arprot_i,
  output logic [1:0]                   s_rvalid_o,
  input  logic [1:0]                   s_rready_i,
  output logic [1:0][DATA_W-1:0]       s_rdata_o,
  output logic [1:0][1:0]              s_rresp_o,
  // downstream shared slave
  output logic                         m_awvalid_o,
  input  logic                         m_awready_i,
  output logic [ADDR_W-1:0]            m_awaddr_o,
  output logic [2:0]                   m_awprot_o,
  output logic                         m_wvalid_o,
  input  logic                         m_wready_i,
  output logic [DATA_W-1:0]            m_wdata_o,
  output logic [DATA_W/8-1:0]          m_wstrb_o,
  input  logic                         m_bvalid_i,
  output logic                         m_bready_o,
  input  logic [1:0]                   m_bresp_i,
  output logic                         m_arvalid_o,
  input  logic                         m_arready_i,
  output logic [ADDR_W-1:0]            m_araddr_o,
  output logic [2:0]                   m_arprot_o,
  input  logic                         m_rvalid_i,
  output logic                         m_rready_o,
  input  logic [DATA_W-1:0]            m_rdata_i,
  input  logic [1:0]                   m_rresp_i
);

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_RESP} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic      wr_gnt_q, wr_gnt_d, wr_pri_q, wr_pri_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic      rd_gnt_q, rd_gnt_d, rd_pri_q, rd_pri_d;
  logic      aw_hs, w_hs;

  // A lone requester always wins; on a tie the priority bit names the winner.
  function automatic logic pick(input logic [1:0] req, input logic pri);
    if (req == 2'b11) return pri;
    return req[1];
  endfunction

  // ---- registered arbiter state ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      wr_gnt_q   <= 1'b0;
      wr_pri_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_gnt_q   <= 1'b0;
      rd_pri_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_pri_q   <= wr_pri_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_pri_q   <= rd_pri_d;
    end
  end

  // ---- write channel: next state and handshake routing ----
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_gnt_d    = wr_gnt_q;
    wr_pri_d    = wr_pri_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    s_awready_o = 2'b00;
    s_wready_o  = 2'b00;
    s_bvalid_o  = 2'b00;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (|s_awvalid_i) begin
          wr_gnt_d   = pick(s_awvalid_i, wr_pri_q);
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        // Once a beat has been accepted its valid is masked so the slave
        // never sees a second AW or W for this transaction.
        m_awvalid_o           = s_awvalid_i[wr_gnt_q] & ~aw_done_q;
        m_wvalid_o            = s_wvalid_i[wr_gnt_q] & ~w_done_q;
        s_awready_o[wr_gnt_q] = m_awready_i & ~aw_done_q;
        s_wready_o[wr_gnt_q]  = m_wready_i & ~w_done_q;
        aw_hs     = s_awvalid_i[wr_gnt_q] & ~aw_done_q & m_awready_i;
        w_hs      = s_wvalid_i[wr_gnt_q] & ~w_done_q & m_wready_i;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        s_bvalid_o[wr_gnt_q] = m_bvalid_i;
        m_bready_o           = s_bready_i[wr_gnt_q];
        if (m_bvalid_i && s_bready_i[wr_gnt_q]) begin
          wr_state_d = WR_IDLE;
          if (RR) wr_pri_d = ~wr_gnt_q;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // ---- read channel: next state and handshake routing ----
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_gnt_d    = rd_gnt_q;
    rd_pri_d    = rd_pri_q;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    s_arready_o = 2'b00;
    s_rvalid_o  = 2'b00;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (|s_arvalid_i) begin
          rd_gnt_d   = pick(s_arvalid_i, rd_pri_q);
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        m_arvalid_o           = s_arvalid_i[rd_gnt_q];
        s_arready_o[rd_gnt_q] = m_arready_i;
        if (s_arvalid_i[rd_gnt_q] && m_arready_i) rd_state_d = RD_RESP;
      end
      RD_RESP: begin
        s_rvalid_o[rd_gnt_q] = m_rvalid_i;
        m_rready_o           = s_rready_i[rd_gnt_q];
        if (m_rvalid_i && s_rready_i[rd_gnt_q]) begin
          rd_state_d = RD_IDLE;
          if (RR) rd_pri_d = ~rd_gnt_q;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // ---- payload muxes (don't-care whenever the matching valid is low) ----
  assign m_awaddr_o = s_awaddr_i[wr_gnt_q];
  assign m_awprot_o = s_awprot_i[wr_gnt_q];
  assign m_wdata_o  = s_wdata_i[wr_gnt_q];
  assign m_wstrb_o  = s_wstrb_i[wr_gnt_q];
  assign m_araddr_o = s_araddr_i[rd_gnt_q];
  assign m_arprot_o = s_arprot_i[rd_gnt_q];
  assign s_bresp_o  = {m_bresp_i, m_bresp_i};
  assign s_rdata_o  = {m_rdata_i, m_rdata_i};
  assign s_rresp_o  = {m_rresp_i, m_rresp_i};

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
module tb_axi4_lite_rr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // shared stimulus
  logic [1:0]          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [1:0][AW-1:0]  s_awaddr, s_araddr;
  logic [1:0][2:0]     s_awprot, s_arprot;
  logic [1:0][DW-1:0]  s_wdata;
  logic [1:0][DW/8-1:0] s_wstrb;
  logic                m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]          m_bresp, m_rresp;
  logic [DW-1:0]       m_rdata;

  // round-robin instance outputs
  logic [1:0]          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0][1:0]     s_bresp, s_rresp;
  logic [1:0][DW-1:0]  s_rdata;
  logic                m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [AW-1:0]       m_awaddr, m_araddr;
  logic [2:0]          m_awprot, m_arprot;
  logic [DW-1:0]       m_wdata;
  logic [DW/8-1:0]     m_wstrb;

  // fixed-priority instance outputs
  logic [1:0]          fp_s_awready, fp_s_wready, fp_s_bvalid, fp_s_arready, fp_s_rvalid;
  logic [1:0][1:0]     fp_s_bresp, fp_s_rresp;
  logic [1:0][DW-1:0]  fp_s_rdata;
  logic                fp_m_awvalid, fp_m_wvalid, fp_m_bready, fp_m_arvalid, fp_m_rready;
  logic [AW-1:0]       fp_m_awaddr, fp_m_araddr;
  logic [2:0]          fp_m_awprot, fp_m_arprot;
  logic [DW-1:0]       fp_m_wdata;
  logic [DW/8-1:0]     fp_m_wstrb;

  axi4_lite_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid_i(s_awvalid), .s_awready_o(s_awready), .s_awaddr_i(s_awaddr), .s_awprot_i(s_awprot),
    .s_wvalid_i(s_wvalid), .s_wready_o(s_wready), .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb),
    .s_bvalid_o(s_bvalid), .s_bready_i(s_bready), .s_bresp_o(s_bresp),
    .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_araddr_i(s_araddr), .s_arprot_i(s_arprot),
    .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rdata_o(s_rdata), .s_rresp_o(s_rresp),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .m_bresp_i(m_bresp),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr), .m_arprot_o(m_arprot),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp)
  );

  axi4_lite_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1'b0)) dut_fp (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid_i(s_awvalid), .s_awready_o(fp_s_awready), .s_awaddr_i(s_awaddr), .s_awprot_i(s_awprot),
    .s_wvalid_i(s_wvalid), .s_wready_o(fp_s_wready), .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb),
    .s_bvalid_o(fp_s_bvalid), .s_bready_i(s_bready), .s_bresp_o(fp_s_bresp),
    .s_arvalid_i(s_arvalid), .s_arready_o(fp_s_arready), .s_araddr_i(s_araddr), .s_arprot_i(s_arprot),
    .s_rvalid_o(fp_s_rvalid), .s_rready_i(s_rready), .s_rdata_o(fp_s_rdata), .s_rresp_o(fp_s_rresp),
    .m_awvalid_o(fp_m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(fp_m_awaddr), .m_awprot_o(fp_m_awprot),
    .m_wvalid_o(fp_m_wvalid), .m_wready_i(m_wready), .m_wdata_o(fp_m_wdata), .m_wstrb_o(fp_m_wstrb),
    .m_bvalid_i(m_bvalid), .m_bready_o(fp_m_bready), .m_bresp_i(m_bresp),
    .m_arvalid_o(fp_m_arvalid), .m_arready_i(m_arready), .m_araddr_o(fp_m_araddr), .m_arprot_o(fp_m_arprot),
    .m_rvalid_i(m_rvalid), .m_rready_o(fp_m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int aw_beats = 0;
  int w_beats  = 0;
  int aw0, w0;

  // downstream beat counters for the round-robin instance
  always @(posedge aclk) begin
    if (m_awvalid && m_awready) aw_beats <= aw_beats + 1;
    if (m_wvalid && m_wready)   w_beats  <= w_beats + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn   = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    s_awaddr  = {32'h0000_0020, 32'h0000_0010};
    s_araddr  = {32'h0000_0200, 32'h0000_0100};
    s_awprot  = '0; s_arprot = '0; s_wdata = '0; s_wstrb = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    m_bresp   = '0; m_rresp = '0; m_rdata = '0;

    // reset state
    @(negedge aclk); #1;
    check("rst_m_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    check("rst_s_readys", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 0);

    // single write from master 0
    @(negedge aclk);
    aresetn = 1'b1;
    s_awvalid = 2'b01; s_wvalid = 2'b01; s_bready = 2'b01;
    s_wdata[0] = 32'hDEAD_BEEF; s_wstrb[0] = 4'hF;
    m_awready = 1'b1; m_wready = 1'b1;
    #1 check("wr1_idle_awvalid", m_awvalid, 0);
    @(negedge aclk); #1;
    check("wr1_m_aw", {m_awvalid, m_awaddr}, {1'b1, 32'h10});
    check("wr1_m_w", {m_wvalid, m_wstrb, m_wdata}, {1'b1, 4'hF, 32'hDEAD_BEEF});
    check("wr1_s_ready", {s_awready, s_wready}, 4'b0101);
    @(negedge aclk);
    s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1; m_bresp = 2'b00;
    #1 check("wr1_b", {s_bvalid, s_bresp[0], m_bready}, {2'b01, 2'b00, 1'b1});
    check("wr1_m1_quiet", {s_awready[1], s_wready[1], s_bvalid[1], s_arready[1], s_rvalid[1]}, 0);
    @(negedge aclk);
    m_bvalid = 1'b0; s_bready = 2'b00;
    #1 check("wr1_done", {s_bvalid, m_awvalid, m_wvalid}, 0);

    // tied reads, round-robin: grant order 0,1,0,1,...
    s_arvalid = 2'b11; s_rready = 2'b11; m_arready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge aclk);
        m_rvalid = 1'b0;
      end
      @(negedge aclk); #1;
      check($sformatf("rr_ar%0d", k), {m_arvalid, m_araddr}, {1'b1, ((k % 2) ? 32'h200 : 32'h100)});
      check($sformatf("rr_arready%0d", k), s_arready, ((k % 2) ? 2'b10 : 2'b01));
      @(negedge aclk);
      m_rvalid = 1'b1;
      m_rdata  = ((k % 2) ? 32'hB0 : 32'hA0) + 32'(k / 2);
      #1 check($sformatf("rr_rvalid%0d", k), s_rvalid, ((k % 2) ? 2'b10 : 2'b01));
      check($sformatf("rr_rdata%0d", k), s_rdata[k % 2], ((k % 2) ? 32'hB0 : 32'hA0) + 32'(k / 2));
    end

    // tied reads, fixed priority: master 0 wins every tie
    @(negedge aclk);
    m_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge aclk);
        m_rvalid = 1'b0;
        if (k == 3) s_arvalid = 2'b10;
      end
      @(negedge aclk); #1;
      check($sformatf("fp_araddr%0d", k), fp_m_araddr, ((k == 3) ? 32'h200 : 32'h100));
      check($sformatf("fp_arready%0d", k), fp_s_arready, ((k == 3) ? 2'b10 : 2'b01));
      @(negedge aclk);
      m_rvalid = 1'b1; m_rdata = 32'(k);
      #1 check($sformatf("fp_rvalid%0d", k), fp_s_rvalid, ((k == 3) ? 2'b10 : 2'b01));
    end

    // W before AW from master 1, slave holds awready low for 2 cycles
    @(negedge aclk);
    m_rvalid = 1'b0; s_arvalid = 2'b00; s_rready = 2'b00;
    s_wvalid = 2'b10; s_wdata[1] = 32'h1234_5678; s_wstrb[1] = 4'h3;
    s_bready = 2'b10; m_awready = 1'b0; m_wready = 1'b1;
    aw0 = aw_beats; w0 = w_beats;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge aclk);
      #1 check($sformatf("wfirst_idle%0d", j), {m_wvalid, s_wready, m_bready}, 0);
    end
    @(negedge aclk);
    s_awvalid = 2'b10;
    #1 check("wfirst_arb_lat", m_awvalid, 0);
    @(negedge aclk); #1;
    check("wfirst_fwd", {m_awvalid, m_wvalid, m_awaddr}, {2'b11, 32'h20});
    check("wfirst_rdy", {s_awready, s_wready, m_bready}, {2'b00, 2'b10, 1'b0});
    @(negedge aclk);
    s_wvalid = 2'b00;
    #1 check("wfirst_wdone", {m_awvalid, m_wvalid, m_bready}, 3'b100);
    @(negedge aclk);
    m_awready = 1'b1;
    #1 check("wfirst_aw_hs", {s_awready, m_bready}, {2'b10, 1'b0});
    @(negedge aclk);
    s_awvalid = 2'b00; m_bvalid = 1'b1; m_bresp = 2'b10;
    #1 check("wfirst_b", {s_bvalid, s_bresp[1], m_bready}, {2'b10, 2'b10, 1'b1});
    check("wfirst_aw_beats", aw_beats - aw0, 1);
    check("wfirst_w_beats", w_beats - w0, 1);

    // concurrent write (master 0) and read (master 1), bvalid stalled
    @(negedge aclk);
    m_bvalid = 1'b0; m_bresp = 2'b00;
    s_bready = 2'b01; s_awvalid = 2'b01; s_wvalid = 2'b01; s_wdata[0] = 32'hCAFE_F00D;
    s_arvalid = 2'b10; s_rready = 2'b10; m_arready = 1'b1;
    @(negedge aclk); #1;
    check("conc_valids", {m_awvalid, m_wvalid, m_arvalid, m_araddr}, {3'b111, 32'h200});
    check("conc_readys", {s_awready, s_arready}, {2'b01, 2'b10});
    @(negedge aclk);
    s_awvalid = 2'b00; s_wvalid = 2'b00; s_arvalid = 2'b00;
    m_rvalid = 1'b1; m_rdata = 32'h5A5A_5A5A;
    #1 check("conc_r", {s_rvalid, s_bvalid, s_rdata[1]}, {2'b10, 2'b00, 32'h5A5A_5A5A});
    for (int j = 0; j < 4; j++) begin
      @(negedge aclk);
      m_rvalid = 1'b0;
      #1 check($sformatf("conc_stall%0d", j), {s_bvalid, s_rvalid, m_bready}, 5'b00001);
    end
    @(negedge aclk);
    m_bvalid = 1'b1;
    #1 check("conc_b", {s_bvalid, s_rvalid}, {2'b01, 2'b00});

    // reset during WR_RESP; write priority now points at master 1
    @(negedge aclk);
    m_bvalid = 1'b0;
    s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
    @(negedge aclk); #1;
    check("rst_pre_gnt", {m_awvalid, m_awaddr, s_awready}, {1'b1, 32'h20, 2'b10});
    @(negedge aclk);
    m_bvalid = 1'b1;
    #1 check("rst_pre_b", {s_bvalid, m_bready}, {2'b10, 1'b1});
    #2 aresetn = 1'b0;
    #1 check("rst_async_drop", {s_bvalid, m_bready, m_awvalid, m_wvalid, s_awready, s_wready}, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1 check("rst_no_replay", {s_bvalid, m_bready, m_awvalid}, 0);
    @(negedge aclk);
    m_bvalid = 1'b0;
    #1 check("rst_first_tie", {m_awvalid, m_awaddr, s_awready}, {1'b1, 32'h10, 2'b01});
    @(negedge aclk);
    s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1;
    #1 check("rst_after_b", s_bvalid, 2'b01);
    @(negedge aclk);
    m_bvalid = 1'b0; s_bready = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
